// File: rtl/prefetch_buffer_pkg.sv
// Local constants and helpers for the instruction prefetch buffer.
package prefetch_buffer_pkg;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  // Next sequential word address, 32-bit modulo (0xFFFFFFFC -> 0x0).
  function automatic logic [31:0] next_word(input logic [31:0] a);
    return a + WORD_BYTES;
  endfunction

endpackage

// File: rtl/wires.sv
// Shared memory-port types used between the core, the prefetch buffer
// and the memory arbiter.
//   mem_in_type  : request  (valid, instr, addr, wdata, wstrb)
//   mem_out_type : response (ready, rdata)
package wires;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

endpackage

// File: rtl/prefetch_fifo.sv
// Word storage for the prefetch buffer: 2^depth_log x 32 bits.
// Pointer and occupancy bookkeeping lives in the parent.
//   clk   : clock
//   we    : write enable, waddr/wdata : write port
//   raddr : read address, rdata : asynchronous read data
module prefetch_fifo #(
  parameter int unsigned depth_log = 2
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [depth_log-1:0] waddr,
  input  logic [31:0]          wdata,
  input  logic [depth_log-1:0] raddr,
  output logic [31:0]          rdata
);

  logic [(1<<depth_log)-1:0][31:0] mem;

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/prefetch_buffer.sv
// Instruction prefetch buffer between the core fetch stage and the memory
// arbiter's instruction port. Fetches sequential words ahead of the core,
// one outstanding at a time, buffers them, and serves core requests from
// the buffer. A non-sequential request flushes and restarts prefetching.
//   rst         : asynchronous active-low reset
//   clk         : clock
//   fetch_in    : core request (valid pulse + word address)
//   fetch_out   : core response (ready pulse + instruction word)
//   fetch_flush : invalidate buffered words (fence.i)
//   imem_req    : request to arbiter instruction port
//   imem_rsp    : arbiter response
// Build option: define PREFETCH_FORWARD_EN to hand a returning word to a
// waiting core request in the same cycle it arrives; otherwise it is
// delivered one cycle later from the buffer.
module prefetch_buffer
  import wires::*;
  import prefetch_buffer_pkg::*;
#(
  parameter int unsigned depth_log  = 2,
  parameter logic [31:0] reset_addr = 32'h0
) (
  input  logic        rst,
  input  logic        clk,
  input  mem_in_type  fetch_in,
  output mem_out_type fetch_out,
  input  logic        fetch_flush,
  output mem_in_type  imem_req,
  input  mem_out_type imem_rsp
);

  localparam int unsigned         DEPTH    = 1 << depth_log;
  localparam logic [depth_log:0]   CNT_FULL = (depth_log+1)'(DEPTH);
  localparam logic [depth_log:0]   CNT_ONE  = (depth_log+1)'(1);
  localparam logic [depth_log-1:0] PTR_ONE  = depth_log'(1);

  typedef struct packed {
    logic [31:0]          fetch_addr;
    logic [31:0]          head_addr;
    logic [depth_log:0]   count;
    logic [depth_log-1:0] rd_ptr;
    logic [depth_log-1:0] wr_ptr;
    logic                 outstanding;
    logic                 discard;
    logic                 req_pending;
    logic [31:0]          req_addr;
  } reg_type;

  localparam reg_type INIT = '{
    fetch_addr:  reset_addr,
    head_addr:   reset_addr,
    count:       '0,
    rd_ptr:      '0,
    wr_ptr:      '0,
    outstanding: 1'b0,
    discard:     1'b0,
    req_pending: 1'b0,
    req_addr:    '0
  };

  reg_type            r, v;
  logic               rsp_acc, miss, push, hit, issue;
  logic [depth_log:0] avail;
  logic [31:0]        hit_data, issue_addr, fifo_rdata;

  // Write data/strobe of the core port carry no meaning for instruction fetch.
  logic unused_fetch_fields;
  assign unused_fetch_fields = ^{fetch_in.mem_wdata, fetch_in.mem_wstrb, fetch_in.mem_instr};

  prefetch_fifo #(.depth_log(depth_log)) u_fifo (
    .clk   (clk),
    .we    (push),
    .waddr (r.wr_ptr),
    .wdata (imem_rsp.mem_rdata),
    .raddr (r.rd_ptr),
    .rdata (fifo_rdata)
  );

  always_comb begin
    v          = r;
    push       = 1'b0;
    hit        = 1'b0;
    issue      = 1'b0;
    issue_addr = '0;
    fetch_out  = '0;
    imem_req   = '0;

    // A response with nothing in flight is stale (e.g. crossed a reset).
    rsp_acc = imem_rsp.mem_ready & r.outstanding;

    // A new pulse replaces any pending request.
    if (fetch_in.mem_valid) begin
      v.req_pending = 1'b1;
      v.req_addr    = fetch_in.mem_addr;
    end

    miss = v.req_pending && (v.req_addr != r.head_addr);

    if (rsp_acc) begin
      v.outstanding = 1'b0;
      if (r.discard)                  v.discard = 1'b0;
      else if (!miss && !fetch_flush) push      = 1'b1;
    end
    if (push) begin
      v.wr_ptr = r.wr_ptr + PTR_ONE;
      v.count  = r.count + CNT_ONE;
    end

    // Restart at the requested address; a word still in flight belongs to
    // the old stream and is dropped when it lands.
    if (miss) begin
      v.count      = '0;
      v.rd_ptr     = '0;
      v.wr_ptr     = '0;
      v.head_addr  = v.req_addr;
      v.fetch_addr = v.req_addr;
      v.discard    = v.outstanding;
    end

    if (fetch_flush) begin
      v.count      = '0;
      v.rd_ptr     = '0;
      v.wr_ptr     = '0;
      v.discard    = v.outstanding;
      v.fetch_addr = v.head_addr;
    end

`ifdef PREFETCH_FORWARD_EN
    avail    = v.count;
    // Empty before this cycle means the only word is the one arriving now.
    hit_data = (r.count == '0) ? imem_rsp.mem_rdata : fifo_rdata;
`else
    avail    = push ? (v.count - CNT_ONE) : v.count;
    hit_data = fifo_rdata;
`endif

    hit = v.req_pending && (avail != '0) && (v.req_addr == v.head_addr);
    if (hit) begin
      v.rd_ptr      = v.rd_ptr + PTR_ONE;
      v.count       = v.count - CNT_ONE;
      v.head_addr   = next_word(v.head_addr);
      v.req_pending = 1'b0;
    end

    // Evaluated after pop so a freed slot refills in the same cycle.
    issue = rst && !v.outstanding && (v.count < CNT_FULL);
    if (issue) begin
      issue_addr    = v.fetch_addr;
      v.fetch_addr  = next_word(v.fetch_addr);
      v.outstanding = 1'b1;
    end

    // Outputs held low while reset is asserted.
    fetch_out.mem_ready = hit & rst;
    fetch_out.mem_rdata = (hit & rst) ? hit_data : '0;
    imem_req.mem_valid  = issue;
    imem_req.mem_addr   = issue_addr;
    imem_req.mem_instr  = rst;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) r <= INIT;
    else      r <= v;

endmodule

// File: tb/tb_prefetch_buffer.sv
module tb_prefetch_buffer;
  import wires::*;

`ifdef PREFETCH_FORWARD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  mem_in_type  fetch_in;
  mem_out_type fetch_out;
  logic        fetch_flush;
  mem_in_type  imem_req;
  mem_out_type imem_rsp;

  mem_in_type  w_fetch_in;
  mem_out_type w_fetch_out;
  logic        w_flush;
  mem_in_type  w_req;
  mem_out_type w_rsp;

  always #5 clk = ~clk;

  prefetch_buffer #(.depth_log(2), .reset_addr(32'h0)) dut (
    .rst(rst), .clk(clk), .fetch_in(fetch_in), .fetch_out(fetch_out),
    .fetch_flush(fetch_flush), .imem_req(imem_req), .imem_rsp(imem_rsp));

  prefetch_buffer #(.depth_log(2), .reset_addr(32'hFFFF_FFF8)) dut_w (
    .rst(rst), .clk(clk), .fetch_in(w_fetch_in), .fetch_out(w_fetch_out),
    .fetch_flush(w_flush), .imem_req(w_req), .imem_rsp(w_rsp));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rel_cyc  = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference memory contents: a fixed hash of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Arbiter model: one request at a time, fixed or random latency.
  logic [31:0] iss_addr[$];
  int          iss_cyc[$];
  logic [31:0] rsp_addr[$];
  int          rsp_cyc[$];
  int          arb_lat  = 2;
  bit          arb_rand = 0;
  bit          arb_busy = 0;
  int          arb_cnt  = 0;
  logic [31:0] arb_a    = '0;

  initial begin
    imem_rsp = '0;
    forever begin
      @(posedge clk); #1;
      imem_rsp = '0;
      if (!rst) arb_busy = 0;
      else if (arb_busy) begin
        arb_cnt--;
        if (arb_cnt == 0) begin
          imem_rsp.mem_ready = 1'b1;
          imem_rsp.mem_rdata = mem_word(arb_a);
          arb_busy = 0;
          rsp_addr.push_back(arb_a);
          rsp_cyc.push_back(cyc);
        end
      end
      @(negedge clk);
      if (rst && imem_req.mem_valid === 1'b1) begin
        n_checks++;
        if (arb_busy || imem_req.mem_instr !== 1'b1 || imem_req.mem_wstrb !== 4'h0 ||
            imem_req.mem_wdata !== 32'h0)
          $display("FAIL issue_protocol: busy=%0d instr=%b wstrb=%h wdata=%h, expected busy=0 instr=1 wstrb=0 wdata=0",
                   arb_busy, imem_req.mem_instr, imem_req.mem_wstrb, imem_req.mem_wdata);
        else n_pass++;
        arb_busy = 1;
        arb_a    = imem_req.mem_addr;
        arb_cnt  = arb_rand ? int'($urandom_range(1, 4)) : arb_lat;
        iss_addr.push_back(imem_req.mem_addr);
        iss_cyc.push_back(cyc);
      end
    end
  end

  // Latency-1 responder for the wrap-around instance.
  logic [31:0] w_iss[$];
  bit          w_pend = 0;
  logic [31:0] w_a    = '0;

  initial begin
    w_rsp = '0;
    w_fetch_in = '0;
    w_flush = 1'b0;
    forever begin
      @(posedge clk); #1;
      w_rsp = '0;
      if (rst && w_pend) begin
        w_rsp.mem_ready = 1'b1;
        w_rsp.mem_rdata = mem_word(w_a);
      end
      w_pend = 0;
      @(negedge clk);
      if (rst && w_req.mem_valid === 1'b1) begin
        w_pend = 1;
        w_a    = w_req.mem_addr;
        w_iss.push_back(w_req.mem_addr);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    fetch_in = '0;
    fetch_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    iss_addr.delete(); iss_cyc.delete(); rsp_addr.delete(); rsp_cyc.delete(); w_iss.delete();
    rst = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic core_fetch(input logic [31:0] a, output bit ok, output int lat,
                            output logic [31:0] d, output int req_c);
    ok = 0; lat = -1; d = '0;
    @(posedge clk); #1;
    fetch_in.mem_valid = 1'b1;
    fetch_in.mem_addr  = a;
    req_c = cyc;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fetch_out.mem_ready === 1'b1) begin
        ok = 1; lat = i; d = fetch_out.mem_rdata;
      end
      @(posedge clk); #1;
      fetch_in.mem_valid = 1'b0;
      if (ok) break;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    fetch_in.mem_valid = 1'b1;
    fetch_in.mem_addr  = 32'h40;
    @(negedge clk);
    n_checks++;
    if (fetch_out !== '0) $display("FAIL reset_fetch_out: got %h, expected 0", fetch_out);
    else n_pass++;
    n_checks++;
    if (imem_req.mem_valid !== 1'b0 || imem_req.mem_addr !== 32'h0)
      $display("FAIL reset_imem_req: got valid=%b addr=%h, expected valid=0 addr=0",
               imem_req.mem_valid, imem_req.mem_addr);
    else n_pass++;
    do_reset();
    @(negedge clk);
    n_checks++;
    if (imem_req.mem_valid !== 1'b1 || imem_req.mem_addr !== 32'h0 || imem_req.mem_instr !== 1'b1)
      $display("FAIL first_issue: got valid=%b addr=%h instr=%b, expected valid=1 addr=0 instr=1",
               imem_req.mem_valid, imem_req.mem_addr, imem_req.mem_instr);
    else n_pass++;
  endtask

  task automatic test_sequential();
    bit ok; int lat; int rc; logic [31:0] d;
    arb_rand = 0; arb_lat = 2;
    do_reset();
    core_fetch(32'h0, ok, lat, d, rc);
    n_checks++;
    if (!ok || d !== mem_word(32'h0)) $display("FAIL seq_word0: ok=%0d got %h, expected %h", ok, d, mem_word(32'h0));
    else n_pass++;
    // issue @0, response @2, request made @1
    n_checks++;
    if (lat !== 2 - FWD) $display("FAIL seq_word0_latency: got %0d, expected %0d", lat, 2 - FWD);
    else n_pass++;
    repeat (12) @(posedge clk);
    for (int k = 1; k <= 2; k++) begin
      core_fetch(32'(4 * k), ok, lat, d, rc);
      n_checks++;
      if (!ok || lat !== 0 || d !== mem_word(32'(4 * k)))
        $display("FAIL seq_buffered_hit: addr=%h ok=%0d lat=%0d data=%h, expected lat=0 data=%h",
                 4 * k, ok, lat, d, mem_word(32'(4 * k)));
      else n_pass++;
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (iss_addr.size() <= k) $display("FAIL seq_issue_order: issue %0d missing, expected addr %h", k, 4 * k);
      else if (iss_addr[k] !== 32'(4 * k))
        $display("FAIL seq_issue_order: issue %0d got %h, expected %h", k, iss_addr[k], 4 * k);
      else n_pass++;
    end
  endtask

  task automatic test_fill_and_branch();
    bit ok; int lat; int rc; logic [31:0] d;
    arb_rand = 0; arb_lat = 4;
    do_reset();
    repeat (25) @(posedge clk);
    n_checks++;
    if (iss_addr.size() != 4) $display("FAIL full_issue_count: got %0d, expected 4", iss_addr.size());
    else n_pass++;
    for (int k = 0; k < 4 && k < iss_addr.size(); k++) begin
      n_checks++;
      if (iss_addr[k] !== 32'(4 * k)) $display("FAIL full_issue_addr: issue %0d got %h, expected %h", k, iss_addr[k], 4 * k);
      else n_pass++;
    end
    // Pop from a full buffer: refill issue in the same cycle.
    core_fetch(32'h0, ok, lat, d, rc);
    n_checks++;
    if (!ok || lat !== 0 || d !== mem_word(32'h0))
      $display("FAIL full_pop: ok=%0d lat=%0d data=%h, expected lat=0 data=%h", ok, lat, d, mem_word(32'h0));
    else n_pass++;
    n_checks++;
    if (iss_addr.size() < 5 || iss_addr[4] !== 32'h10 || iss_cyc[4] != rc)
      $display("FAIL full_pop_refill: issues=%0d, expected issue of 00000010 in cycle %0d", iss_addr.size(), rc);
    else n_pass++;
    // Branch away while 0x10 is still in flight.
    core_fetch(32'h100, ok, lat, d, rc);
    n_checks++;
    if (!ok || d !== mem_word(32'h100))
      $display("FAIL branch_data: ok=%0d got %h, expected %h", ok, d, mem_word(32'h100));
    else n_pass++;
    n_checks++;
    if (iss_addr.size() < 6 || iss_addr[5] !== 32'h100)
      $display("FAIL branch_refetch: issues=%0d, expected sixth issue at 00000100", iss_addr.size());
    else n_pass++;
    core_fetch(32'h104, ok, lat, d, rc);
    n_checks++;
    if (!ok || d !== mem_word(32'h104))
      $display("FAIL branch_next: ok=%0d got %h, expected %h", ok, d, mem_word(32'h104));
    else n_pass++;
  endtask

  task automatic test_flush();
    bit ok; int lat; int rc; logic [31:0] d;
    arb_rand = 0; arb_lat = 4;
    do_reset();
    repeat (25) @(posedge clk);
    core_fetch(32'h0, ok, lat, d, rc);   // leaves 3 buffered, 0x10 in flight
    fetch_flush = 1'b1;
    @(posedge clk); #1;
    fetch_flush = 1'b0;
    core_fetch(32'h4, ok, lat, d, rc);
    n_checks++;
    if (!ok || d !== mem_word(32'h4))
      $display("FAIL flush_data: ok=%0d got %h, expected %h", ok, d, mem_word(32'h4));
    else n_pass++;
    n_checks++;
    if (lat <= 0) $display("FAIL flush_not_buffered: latency %0d, expected > 0", lat);
    else n_pass++;
    n_checks++;
    if (iss_addr.size() < 6 || iss_addr[5] !== 32'h4)
      $display("FAIL flush_refetch: issues=%0d, expected sixth issue at 00000004", iss_addr.size());
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_w[3];
    exp_w[0] = 32'hFFFF_FFF8; exp_w[1] = 32'hFFFF_FFFC; exp_w[2] = 32'h0;
    do_reset();
    repeat (12) @(posedge clk);
    n_checks++;
    if (w_iss.size() != 4) $display("FAIL wrap_issue_count: got %0d, expected 4", w_iss.size());
    else n_pass++;
    for (int k = 0; k < 3 && k < w_iss.size(); k++) begin
      n_checks++;
      if (w_iss[k] !== exp_w[k]) $display("FAIL wrap_issue_addr: issue %0d got %h, expected %h", k, w_iss[k], exp_w[k]);
      else n_pass++;
    end
  endtask

  task automatic test_forward();
    bit ok; int lat; int rc; logic [31:0] d;
    arb_rand = 0; arb_lat = 3;
    do_reset();
    core_fetch(32'h0, ok, lat, d, rc);
    n_checks++;
    if (!ok || d !== mem_word(32'h0))
      $display("FAIL fwd_data: ok=%0d got %h, expected %h", ok, d, mem_word(32'h0));
    else n_pass++;
    n_checks++;
    if (rsp_cyc.size() == 0 || rsp_addr[0] !== 32'h0)
      $display("FAIL fwd_timing: no response for 00000000 recorded");
    else if (rc + lat != rsp_cyc[0] + 1 - FWD)
      $display("FAIL fwd_timing: delivered cycle %0d, expected %0d", rc + lat, rsp_cyc[0] + 1 - FWD);
    else n_pass++;
  endtask

  task automatic test_random();
    bit ok; int lat; int rc; logic [31:0] d;
    logic [31:0] a;
    arb_rand = 1;
    do_reset();
    a = 32'h0;
    for (int n = 0; n < 80; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      if ($urandom_range(0, 9) == 0) begin
        @(posedge clk); #1;
        fetch_flush = 1'b1;
        @(posedge clk); #1;
        fetch_flush = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 255)) << 2;
      core_fetch(a, ok, lat, d, rc);
      n_checks++;
      if (!ok) $display("FAIL rand_timeout: addr %h not delivered within 100 cycles", a);
      else n_pass++;
      n_checks++;
      if (d !== mem_word(a)) $display("FAIL rand_data: addr %h got %h, expected %h", a, d, mem_word(a));
      else n_pass++;
      a = a + 32'd4;
    end
    arb_rand = 0;
  endtask

  initial begin
    fetch_in = '0;
    fetch_flush = 1'b0;
    test_reset();
    test_sequential();
    test_fill_and_branch();
    test_flush();
    test_wrap();
    test_forward();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
